// File: rtl/sopc_anemometre_leds_if.sv
// ---------------------------------------------------------------------------
// sopc_anemometre_leds_if
// Avalon-MM register bus for the anemometer LED controller.
//   address    : register select (2 bits)
//   chipselect : slave select, active-high
//   write_n    : write strobe, active-low
//   writedata  : write data (32 bits)
//   readdata   : registered read data (32 bits), driven by the slave
// Modports: master (bus host side) and slave (LED controller side).
// ---------------------------------------------------------------------------
interface sopc_anemometre_leds_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/sopc_anemometre_leds.sv
// ---------------------------------------------------------------------------
// sopc_anemometre_leds
// Memory-mapped LED output port with per-bit blinking.
//   Registers (address):
//     0 : data_reg       write = load,   read = data_reg
//     1 : data_reg set   write = OR,     read = out_port
//     2 : data_reg clear write = AND-NOT, read = 0
//     3 : blink_mask     write = load + restart blink, read = blink_mask
//   Ports:
//     clk      : system clock, rising edge
//     reset_n  : asynchronous active-low reset
//     bus      : Avalon-MM slave (sopc_anemometre_leds_if.slave)
//     out_port : registered LED drive, WIDTH bits
// Optional feature macro: LEDS_BLINK_EN. When undefined, there is no blink
// logic, address 3 writes are ignored, address 3 reads 0 and out_port is
// simply data_reg registered.
// ---------------------------------------------------------------------------
module sopc_anemometre_leds #(
    parameter int WIDTH     = 8,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    sopc_anemometre_leds_if.slave   bus,
    output logic [WIDTH-1:0]        out_port
);

    logic             write_s;
    logic [WIDTH-1:0] wdata_s;
    logic [WIDTH-1:0] data_reg_r;
    logic [WIDTH-1:0] data_next_s;
    logic [WIDTH-1:0] out_port_r;
    logic [WIDTH-1:0] out_next_s;
    logic [31:0]      readdata_r;
    logic [31:0]      rd_next_s;
    logic [WIDTH-1:0] mask_view_s;
    logic             unused_s;

    assign write_s  = bus.chipselect & ~bus.write_n;
    assign wdata_s  = bus.writedata[WIDTH-1:0];
    assign unused_s = ^bus.writedata;

    assign out_port     = out_port_r;
    assign bus.readdata = readdata_r;

    // Next data_reg value: load / set / clear according to the written address.
    always_comb begin
        data_next_s = data_reg_r;
        if (write_s) begin
            case (bus.address)
                2'd0:    data_next_s = wdata_s;
                2'd1:    data_next_s = data_reg_r | wdata_s;
                2'd2:    data_next_s = data_reg_r & ~wdata_s;
                default: data_next_s = data_reg_r;
            endcase
        end else begin
            data_next_s = data_reg_r;
        end
    end

`ifdef LEDS_BLINK_EN
    localparam int PW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(BLINK_DIV - 1);

    logic [WIDTH-1:0] blink_mask_r;
    logic [PW-1:0]    prescaler_r;
    logic             blink_phase_r;
    logic             mask_wr_s;

    assign mask_wr_s   = write_s & (bus.address == 2'd3);
    assign mask_view_s = blink_mask_r;

    // Blink timebase; a mask write restarts it and wins over a coincident wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_mask_r  <= {WIDTH{1'b0}};
            prescaler_r   <= {PW{1'b0}};
            blink_phase_r <= 1'b1;
        end else if (mask_wr_s) begin
            blink_mask_r  <= wdata_s;
            prescaler_r   <= {PW{1'b0}};
            blink_phase_r <= 1'b1;
        end else if (prescaler_r == PRESC_MAX) begin
            prescaler_r   <= {PW{1'b0}};
            blink_phase_r <= ~blink_phase_r;
        end else begin
            prescaler_r   <= prescaler_r + {{(PW-1){1'b0}}, 1'b1};
        end
    end

    // Masked bits are gated off during the low blink phase.
    always_comb begin
        out_next_s = data_reg_r & (~blink_mask_r | {WIDTH{blink_phase_r}});
    end
`else
    assign mask_view_s = {WIDTH{1'b0}};

    // Without blinking the pins follow data_reg directly.
    always_comb begin
        out_next_s = data_reg_r;
    end
`endif

    // Read mux, sampled from the registers as they stand before any write lands.
    always_comb begin
        rd_next_s = 32'h0000_0000;
        case (bus.address)
            2'd0:    rd_next_s = 32'(data_reg_r);
            2'd1:    rd_next_s = 32'(out_port_r);
            2'd2:    rd_next_s = 32'h0000_0000;
            default: rd_next_s = 32'(mask_view_s);
        endcase
    end

    // Data, LED drive and read data registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg_r <= {WIDTH{1'b0}};
            out_port_r <= {WIDTH{1'b0}};
            readdata_r <= 32'h0000_0000;
        end else begin
            data_reg_r <= data_next_s;
            out_port_r <= out_next_s;
            readdata_r <= rd_next_s;
        end
    end

endmodule

// File: doc/sopc_anemometre_leds.md
SOPC_ANEMOMETRE_LEDS -- requirements
Module: sopc_anemometre_leds

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the output port width (1..32).
REQ-002 The block SHALL have parameter BLINK_DIV, default 25000000, giving the clk cycles per blink half-period (minimum 2).
REQ-003 The block SHALL have port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port address, input, 2 bits: Avalon-MM register select.
REQ-006 The block SHALL have port chipselect, input, 1 bit: Avalon-MM slave select, active-high.
REQ-007 The block SHALL have port write_n, input, 1 bit: Avalon-MM write strobe, active-low.
REQ-008 The block SHALL have port writedata, input, 32 bits: Avalon-MM write data.
REQ-009 The block SHALL have port readdata, output, 32 bits: registered Avalon-MM read data.
REQ-010 The block SHALL have port out_port, output, WIDTH bits: registered LED drive.

Function
REQ-011 A write SHALL occur on a rising clk edge with chipselect=1 and write_n=0; only writedata[WIDTH-1:0] is used.
REQ-012 A write to address 0 SHALL load data_reg with writedata.
REQ-013 A write to address 1 SHALL set data_reg bits: data_reg | writedata.
REQ-014 A write to address 2 SHALL clear data_reg bits: data_reg & ~writedata.
REQ-015 A write to address 3 SHALL load blink_mask, clear the prescaler to 0 and force blink_phase to 1.
REQ-016 Every cycle, readdata SHALL be loaded with the zero-extended value for the current address: 0 -> data_reg, 1 -> out_port, 2 -> 0, 3 -> blink_mask; read latency is 1 cycle, with no chipselect or read qualifier.
REQ-017 On an edge where a write and the readdata update coincide, readdata SHALL capture the pre-write register value.
REQ-018 Prescaler SHALL count 0..BLINK_DIV-1, wrap to 0 and toggle blink_phase on the wrap cycle.
REQ-019 Per bit, out_port[i] SHALL be registered as data_reg[i] & (~blink_mask[i] | blink_phase).
REQ-020 out_port SHALL reflect a data_reg write on the edge after the write (1-cycle write-to-pin latency).
REQ-021 Bits with blink_mask=0 SHALL follow data_reg steadily; bits with data_reg=0 SHALL stay 0 regardless of blink_mask.
REQ-022 A write to address 3 coinciding with a prescaler wrap SHALL take priority: prescaler 0, blink_phase 1.

Reset
REQ-023 While reset_n=0, data_reg, blink_mask, prescaler, readdata and out_port SHALL be 0, and blink_phase SHALL be 1, asynchronously.
REQ-024 Reset asserted mid-blink or mid-write SHALL abort the operation; after release, counting SHALL restart from 0 on the first clk edge.

Configuration
REQ-025 With macro LEDS_BLINK_EN defined, REQ-015, REQ-018, REQ-019, REQ-021 and REQ-022 SHALL apply as written.
REQ-026 Without LEDS_BLINK_EN, there SHALL be no prescaler or blink_phase logic; writes to address 3 are ignored, address 3 reads 0, and out_port = data_reg registered.

Verification
REQ-027 Write 0xA5 to address 0 -> out_port=0xA5 one cycle later, and address 0 readdata=0x000000A5.
REQ-028 data_reg=0x0F, write 0x30 to address 1 then 0x05 to address 2 -> data_reg=0x3F then 0x3A, and out_port tracks each with 1-cycle lag.
REQ-029 Write 0x1FF to address 0 with WIDTH=8 -> data_reg=0xFF and readdata[31:8]=0.
REQ-030 With BLINK_DIV=4, data_reg=0xFF and blink_mask=0x01 -> out_port bit 0 toggles every 4 cycles and bits 7:1 stay 1; without LEDS_BLINK_EN, out_port stays 0xFF and address 3 reads 0.
REQ-031 Write blink_mask on the prescaler wrap cycle -> prescaler=0 and blink_phase=1 with no toggle.
REQ-032 Assert reset_n=0 mid-blink with data_reg=0x55 -> out_port and readdata=0 immediately without a clk edge, and blink_phase=1.
